// File: rtl/fa_bist_checker.sv
// Built-in self-test for a single-bit full adder: sweeps all 8 {a,b,c} vectors and checks sum/cout.
// Optional per-vector failure mask is built when FA_BIST_FAILMASK_EN is defined.
module fa_bist_checker #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       dut_a,
   output logic       dut_b,
   output logic       dut_c,
   input  logic       dut_sum,
   input  logic       dut_cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] first_fail_vec,
   output logic [7:0] fail_mask
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_WAIT,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] settle_q, settle_d;
   logic [3:0] err_count_q, err_count_d;
   logic [2:0] first_fail_vec_q, first_fail_vec_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;

   logic       exp_sum;
   logic       exp_cout;
   logic       mismatch;
   logic       sweep_start;
   logic       sample_hit;

   // Vector index bits map to {a,b,c}, a being the MSB.
   assign exp_sum     = idx_q[2] ^ idx_q[1] ^ idx_q[0];
   assign exp_cout    = (idx_q[2] & idx_q[1]) | (idx_q[2] & idx_q[0]) | (idx_q[1] & idx_q[0]);
   assign mismatch    = (dut_sum != exp_sum) || (dut_cout != exp_cout);
   assign sweep_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign sample_hit  = (state_q == S_SAMPLE) && mismatch;

   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      settle_d         = settle_q;
      err_count_d      = err_count_q;
      first_fail_vec_d = first_fail_vec_q;
      busy_d           = busy_q;
      done_d           = done_q;
      pass_d           = pass_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d          = S_APPLY;
               idx_d            = '0;
               settle_d         = '0;
               err_count_d      = '0;
               first_fail_vec_d = '0;
               busy_d           = 1'b1;
               done_d           = 1'b0;
               pass_d           = 1'b0;
            end
         end
         S_APPLY: begin
            settle_d = '0;
            state_d  = (SETTLE_CYCLES != 0) ? S_WAIT : S_SAMPLE;
         end
         S_WAIT: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               state_d  = S_SAMPLE;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         S_SAMPLE: begin
            if (mismatch) begin
               err_count_d = err_count_q + 4'd1;
               if (err_count_q == 4'd0) first_fail_vec_d = idx_q;
            end
            if (idx_q == 3'd7) begin
               // pass is taken from the post-update count so it lands with done
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_count_d == 4'd0);
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = S_APPLY;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         idx_q            <= '0;
         settle_q         <= '0;
         err_count_q      <= '0;
         first_fail_vec_q <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         idx_q            <= idx_d;
         settle_q         <= settle_d;
         err_count_q      <= err_count_d;
         first_fail_vec_q <= first_fail_vec_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         pass_q           <= pass_d;
      end
   end

`ifdef FA_BIST_FAILMASK_EN
   logic [7:0] fail_mask_q, fail_mask_d;

   always_comb begin
      fail_mask_d = fail_mask_q;
      if (sweep_start) fail_mask_d = '0;
      else if (sample_hit) fail_mask_d[idx_q] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fail_mask_q <= '0;
      else        fail_mask_q <= fail_mask_d;
   end

   assign fail_mask = fail_mask_q;
`else
   logic unused_mask_ctl;
   assign unused_mask_ctl = sweep_start ^ sample_hit;
   assign fail_mask       = '0;
`endif

   assign dut_a          = idx_q[2];
   assign dut_b          = idx_q[1];
   assign dut_c          = idx_q[0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_count_q;
   assign first_fail_vec = first_fail_vec_q;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Directed bench for fa_bist_checker: two instances (settle 1 and settle 0) each facing a
// behavioural full adder with selectable faults.
module tb_fa_bist_checker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic [1:0] fault0 = 2'd0;   // 0 good, 1 cout stuck-at-0, 2 sum inverted

   int n_checks = 0;
   int n_errors = 0;

   logic a0, b0, c0, sum0, cout0, busy0, done0, pass0;
   logic [3:0] err0;
   logic [2:0] ffv0;
   logic [7:0] mask0;
   logic a1, b1, c1, sum1, cout1, busy1, done1, pass1;
   logic [3:0] err1;
   logic [2:0] ffv1;
   logic [7:0] mask1;
   logic [2:0] vec0, vec1;

   always #5 clk = ~clk;

   assign vec0  = {a0, b0, c0};
   assign vec1  = {a1, b1, c1};
   assign sum0  = (a0 ^ b0 ^ c0) ^ (fault0 == 2'd2);
   assign cout0 = (fault0 == 2'd1) ? 1'b0 : ((a0 & b0) | (a0 & c0) | (b0 & c0));
   assign sum1  = a1 ^ b1 ^ c1;
   assign cout1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

   fa_bist_checker #(.SETTLE_CYCLES(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_sum(sum0), .dut_cout(cout0),
      .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
      .first_fail_vec(ffv0), .fail_mask(mask0)
   );

   fa_bist_checker #(.SETTLE_CYCLES(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_sum(sum1), .dut_cout(cout1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .first_fail_vec(ffv1), .fail_mask(mask1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Start a sweep on instance 0; optionally pulse start again at cycle poke while busy.
   task automatic run0(input int poke, output int cyc);
      logic early_pass;
      early_pass = 1'b0;
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      check("accept_busy", {31'd0, busy0}, 1);
      check("accept_clear", {done0, pass0, err0, ffv0, mask0}, 0);
      cyc = 0;
      while (!done0 && cyc < 400) begin
         if (pass0) early_pass = 1'b1;
         start0 = (cyc == poke);
         @(posedge clk);
         #1;
         cyc++;
      end
      start0 = 1'b0;
      check("done_reached", {31'd0, done0}, 1);
      check("no_early_pass", {31'd0, early_pass}, 0);
      check("busy_at_done", {31'd0, busy0}, 0);
   endtask

   int cyc;
   logic [7:0] exp_mask_cout;
   logic [7:0] exp_mask_sum;

   initial begin
`ifdef FA_BIST_FAILMASK_EN
      exp_mask_cout = 8'hE8;
      exp_mask_sum  = 8'hFF;
`else
      exp_mask_cout = 8'h00;
      exp_mask_sum  = 8'h00;
`endif
      #12;
      check("reset_outs0", {a0, b0, c0, busy0, done0, pass0, err0, ffv0, mask0}, 0);
      check("reset_outs1", {a1, b1, c1, busy1, done1, pass1, err1, ffv1, mask1}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // good adder, settle 1
      run0(-1, cyc);
      check("t1_cycles", cyc, 24);
      check("t1_result", {pass0, err0, ffv0, mask0}, {1'b1, 4'd0, 3'd0, 8'h00});
      check("t1_vec_held", {29'd0, vec0}, 7);

      // start mid-sweep is ignored
      run0(5, cyc);
      check("t5_cycles", cyc, 24);
      check("t5_result", {pass0, err0, ffv0, mask0}, {1'b1, 4'd0, 3'd0, 8'h00});

      fault0 = 2'd1;
      run0(-1, cyc);
      check("t2_result", {pass0, err0, ffv0, mask0}, {1'b0, 4'd4, 3'd3, exp_mask_cout});

      fault0 = 2'd2;
      run0(-1, cyc);
      check("t3_result", {pass0, err0, ffv0, mask0}, {1'b0, 4'd8, 3'd0, exp_mask_sum});

      // settle 0: each vector held two cycles, done after 16
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check($sformatf("t4_vec_%0d", k), {29'd0, vec1}, k / 2);
         check($sformatf("t4_busy_%0d", k), {30'd0, busy1, done1}, 2);
         @(posedge clk);
         #1;
      end
      check("t4_done", {29'd0, done1, pass1, busy1}, 3'b110);
      check("t4_result", {err1, ffv1, mask1}, 0);

      // reset mid-sweep at vector 4 with cout stuck-at-0
      fault0 = 2'd1;
      @(negedge clk);
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      cyc = 0;
      while (vec0 != 3'd4 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("t6_reached_idx4", {29'd0, vec0}, 4);
      check("t6_partial_err", {28'd0, err0}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_reset", {a0, b0, c0, busy0, done0, pass0, err0, ffv0, mask0}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run0(-1, cyc);
      check("t6_cycles", cyc, 24);
      check("t6_result", {pass0, err0, ffv0, mask0}, {1'b0, 4'd4, 3'd3, exp_mask_cout});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
